regfile_rename: RTL and testbench
=================================

// Module: regfile_rename
// PURPOSE
//  Architectural register file with per-register rename tags; sits directly downstream of the ROB commit port.
//  The decoder reads operands (value or producing ROB tag) and, on issue, renames rd to the new ROB entry.
//  The ROB writes committed results here; clear_all (mispredict flush) drops all pending renames.
// PARAMETERS
//  REG_NUM        32  number of architectural registers (x0..x31)
//  REG_ID_BIT     5   register index width, log2(REG_NUM)
//  ROB_WIDTH_BIT  4   ROB tag width
// PORTS
//  clk_in         in   1              clock, all state updates on posedge
//  rst_in         in   1              synchronous reset, active-high
//  rdy_in         in   1              global pause when low; state holds
//  clear_all      in   1              flush from ROB: invalidate every rename tag
//  commit_valid   in   1              ROB commits one result this cycle
//  commit_reg     in   REG_ID_BIT     destination register of the commit
//  commit_rob_id  in   ROB_WIDTH_BIT  ROB entry being committed
//  commit_value   in   32             committed result
//  issue_valid    in   1              decoder issues an instruction that writes rd
//  issue_rd       in   REG_ID_BIT     destination register to rename
//  issue_rob_id   in   ROB_WIDTH_BIT  ROB entry allocated (ROB rob_free_id)
//  rs1            in   REG_ID_BIT     operand 1 index (combinational lookup)
//  rs2            in   REG_ID_BIT     operand 2 index (combinational lookup)
//  rs1_busy       out  1              1: value pending, use rs1_tag
//  rs1_tag        out  ROB_WIDTH_BIT  producing ROB entry for rs1 (valid when rs1_busy)
//  rs1_value      out  32             architectural value of rs1 (valid when !rs1_busy)
//  rs2_busy       out  1              as rs1_busy for rs2
//  rs2_tag        out  ROB_WIDTH_BIT  as rs1_tag for rs2
//  rs2_value      out  32             as rs1_value for rs2
// BEHAVIOUR
//  - State per register: value[31:0], busy, tag[ROB_WIDTH_BIT-1:0]. No other state.
//  - Reset (rst_in=1 at posedge): all value=0, busy=0, tag=0; reset wins over every other input.
//  - rdy_in=0 (no reset): no state change; read outputs still reflect current state.
//  - x0: value always 0, busy always 0; commits and issues with reg 0 are ignored; lookup of 0 returns busy=0, value=0.
//  - Commit (commit_valid=1, commit_reg!=0), 1-cycle latency: value[commit_reg] <= commit_value unconditionally;
//    busy[commit_reg] <= 0 only if busy=1 and tag==commit_rob_id (a younger rename keeps the reg busy).
//  - Issue (issue_valid=1, issue_rd!=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id; value untouched.
//  - Commit and issue to same reg in one cycle: value takes commit_value; busy=1, tag=issue_rob_id (issue wins).
//  - clear_all=1: all busy <= 0 (tags don't care); values remain; a same-cycle commit still writes its value;
//    a same-cycle issue is discarded (clear_all has priority over issue).
//  - Read ports are combinational with commit bypass: if commit_valid && rs==commit_reg && rs!=0 && busy[rs]
//    && tag[rs]==commit_rob_id, output busy=0, value=commit_value. Otherwise output stored busy/tag/value.
//  - Same-cycle issue is NOT bypassed to reads; the decoder sees the rename from the next cycle.
//  - When busy=0, rs*_tag is driven 0.
//  - No internal FSM beyond per-register busy bits; throughput one commit + one issue per cycle.
// TESTING
//  - Reset, then read rs1=5, rs2=0 -> busy=0, value=0, tag=0 for both.
//  - Issue rd=3 tag=7; next cycle read rs1=3 -> busy=1, tag=7; commit reg=3 rob=7 val=0x1234 -> same-cycle bypass busy=0 value=0x1234; next cycle stored busy=0 value=0x1234.
//  - Issue rd=4 tag=2, then issue rd=4 tag=5, then commit reg=4 rob=2 val=9 -> value[4]=9, busy=1, tag=5; commit rob=5 val=11 -> busy=0, value=11.
//  - Same cycle: commit reg=6 rob=1 val=0xAA and issue rd=6 tag=3 -> value=0xAA, busy=1, tag=3.
//  - Rename x1,x2,x3 (tags 1,2,3), assert clear_all with issue rd=8 tag=4 -> all busy=0, x8 not busy, old values kept.
//  - Issue/commit to x0 with val=0xFFFF_FFFF -> x0 reads 0 not busy; rdy_in=0 with commit reg=9 val=5 -> value[9] unchanged.

Source files
------------

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Each register holds a committed value plus a busy/tag pair naming the ROB
// entry that will produce its next value. Operand lookups are combinational
// and forward a same-cycle commit whose tag matches the outstanding rename.
module regfile_rename #(
  parameter int REG_NUM       = 32,
  parameter int REG_ID_BIT    = 5,
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_all,
  input  logic                     commit_valid,
  input  logic [REG_ID_BIT-1:0]    commit_reg,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [31:0]              commit_value,
  input  logic                     issue_valid,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  input  logic [REG_ID_BIT-1:0]    rs1,
  input  logic [REG_ID_BIT-1:0]    rs2,
  output logic                     rs1_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [31:0]              rs1_value,
  output logic                     rs2_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
  output logic [31:0]              rs2_value
);

  // Flattened views of the per-register state, used by the read ports.
  logic [31:0]              value_arr [REG_NUM];
  logic                     busy_arr  [REG_NUM];
  logic [ROB_WIDTH_BIT-1:0] tag_arr   [REG_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : gen_reg
      if (gi == 0) begin : gen_x0
        // x0 is hardwired: never busy, always reads zero.
        assign value_arr[gi] = '0;
        assign busy_arr[gi]  = 1'b0;
        assign tag_arr[gi]   = '0;
      end else begin : gen_xn
        logic [31:0]              value_q, value_d;
        logic                     busy_q, busy_d;
        logic [ROB_WIDTH_BIT-1:0] tag_q, tag_d;
        logic                     commit_hit;
        logic                     issue_hit;

        assign commit_hit = commit_valid && (commit_reg == REG_ID_BIT'(gi));
        assign issue_hit  = issue_valid && (issue_rd == REG_ID_BIT'(gi));

        // Next-state: commit writes the value, a matching commit retires the
        // rename, then flush or a new rename overrides the busy/tag pair.
        always_comb begin
          value_d = value_q;
          busy_d  = busy_q;
          tag_d   = tag_q;
          if (rdy_in) begin
            if (commit_hit) begin
              value_d = commit_value;
              if (busy_q && (tag_q == commit_rob_id)) begin
                busy_d = 1'b0;
              end
            end
            if (clear_all) begin
              busy_d = 1'b0;
            end else if (issue_hit) begin
              busy_d = 1'b1;
              tag_d  = issue_rob_id;
            end
          end
        end

        // State register with synchronous reset.
        always_ff @(posedge clk_in) begin
          if (rst_in) begin
            value_q <= '0;
            busy_q  <= 1'b0;
            tag_q   <= '0;
          end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
          end
        end

        assign value_arr[gi] = value_q;
        assign busy_arr[gi]  = busy_q;
        assign tag_arr[gi]   = tag_q;
      end
    end
  endgenerate

  // Operand lookup result: {busy, tag, value}.
  function automatic logic [ROB_WIDTH_BIT+32:0] lookup(input logic [REG_ID_BIT-1:0] rs);
    logic [ROB_WIDTH_BIT+32:0] res;
    if (commit_valid && (rs == commit_reg) && (rs != '0) && busy_arr[rs] &&
        (tag_arr[rs] == commit_rob_id)) begin
      res = {1'b0, {ROB_WIDTH_BIT{1'b0}}, commit_value};
    end else if (busy_arr[rs]) begin
      res = {1'b1, tag_arr[rs], value_arr[rs]};
    end else begin
      res = {1'b0, {ROB_WIDTH_BIT{1'b0}}, value_arr[rs]};
    end
    return res;
  endfunction

  // Operand port 1 lookup with commit forwarding.
  always_comb begin
    {rs1_busy, rs1_tag, rs1_value} = lookup(rs1);
  end

  // Operand port 2 lookup with commit forwarding.
  always_comb begin
    {rs2_busy, rs2_tag, rs2_value} = lookup(rs2);
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios followed by a
// randomized phase against a small reference model, all through a scoreboard.
module tb_regfile_rename;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_all;
  logic        commit_valid;
  logic [4:0]  commit_reg;
  logic [3:0]  commit_rob_id;
  logic [31:0] commit_value;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_id;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic [3:0]  rs1_tag;
  logic [31:0] rs1_value;
  logic        rs2_busy;
  logic [3:0]  rs2_tag;
  logic [31:0] rs2_value;

  regfile_rename #(.REG_NUM(32), .REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_all(clear_all),
    .commit_valid(commit_valid), .commit_reg(commit_reg),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] v2;
  } exp_t;

  exp_t sb_q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state for the random phase.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic push_exp(input string name,
                          input logic b1, input logic [3:0] t1, input logic [31:0] v1,
                          input logic b2, input logic [3:0] t2, input logic [31:0] v2);
    exp_t e;
    e.name = name;
    e.b1 = b1; e.t1 = t1; e.v1 = v1;
    e.b2 = b2; e.t2 = t2; e.v2 = v2;
    sb_q.push_back(e);
  endtask

  // Let the combinational reads settle, then pop the expectation and compare.
  task automatic eval_reads();
    exp_t e;
    #2;
    e = sb_q.pop_front();
    $display("txn %s rs1=%0d b=%0b t=%0d v=%h | rs2=%0d b=%0b t=%0d v=%h",
             e.name, rs1, rs1_busy, rs1_tag, rs1_value, rs2, rs2_busy, rs2_tag, rs2_value);
    check_val({e.name, ".rs1_busy"},  32'(rs1_busy),  32'(e.b1));
    check_val({e.name, ".rs1_tag"},   32'(rs1_tag),   32'(e.t1));
    check_val({e.name, ".rs1_value"}, rs1_value,      e.v1);
    check_val({e.name, ".rs2_busy"},  32'(rs2_busy),  32'(e.b2));
    check_val({e.name, ".rs2_tag"},   32'(rs2_tag),   32'(e.t2));
    check_val({e.name, ".rs2_value"}, rs2_value,      e.v2);
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; clear_all = 1'b0;
    commit_valid = 1'b0; commit_reg = '0; commit_rob_id = '0; commit_value = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] id, input logic [31:0] v);
    commit_valid = 1'b1; commit_reg = r; commit_rob_id = id; commit_value = v;
  endtask

  task automatic issue(input logic [4:0] r, input logic [3:0] id);
    issue_valid = 1'b1; issue_rd = r; issue_rob_id = id;
  endtask

  task automatic model_read(input logic [4:0] rs, output logic b, output logic [3:0] t,
                            output logic [31:0] v);
    if (commit_valid && rs == commit_reg && rs != 0 && m_busy[rs] && m_tag[rs] == commit_rob_id) begin
      b = 1'b0; t = 4'd0; v = commit_value;
    end else begin
      b = m_busy[rs]; t = m_busy[rs] ? m_tag[rs] : 4'd0; v = m_val[rs];
    end
  endtask

  task automatic model_update();
    if (rdy_in) begin
      if (commit_valid && commit_reg != 0) begin
        m_val[commit_reg] = commit_value;
        if (m_busy[commit_reg] && m_tag[commit_reg] == commit_rob_id) m_busy[commit_reg] = 1'b0;
      end
      if (clear_all) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_id;
      end
    end
  endtask

  initial begin
    logic        b1, b2;
    logic [3:0]  t1, t2;
    logic [31:0] v1, v2;

    idle();
    rst_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();

    rs1 = 5; rs2 = 0;
    push_exp("reset", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();

    // Rename x3 -> 7, commit it with forwarding.
    issue(3, 7); rs1 = 3;
    push_exp("iss3_nobyp", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 3; rs2 = 3;
    push_exp("x3_busy", 1, 7, 0, 1, 7, 0); eval_reads(); next_cycle();
    commit(3, 7, 32'h1234); rs1 = 3;
    push_exp("x3_bypass", 0, 0, 32'h1234, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 3;
    push_exp("x3_stored", 0, 0, 32'h1234, 0, 0, 0); eval_reads(); next_cycle();

    // Stale commit to a re-renamed register keeps it busy.
    issue(4, 2); rs1 = 4;
    push_exp("x4_iss2", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    issue(4, 5); rs1 = 4;
    push_exp("x4_iss5", 1, 2, 0, 0, 0, 0); eval_reads(); next_cycle();
    commit(4, 2, 32'd9); rs1 = 4;
    push_exp("x4_stale_cm", 1, 5, 0, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 4;
    push_exp("x4_after_stale", 1, 5, 32'd9, 0, 0, 0); eval_reads(); next_cycle();
    commit(4, 5, 32'd11); rs1 = 4;
    push_exp("x4_bypass", 0, 0, 32'd11, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 4;
    push_exp("x4_stored", 0, 0, 32'd11, 0, 0, 0); eval_reads(); next_cycle();

    // Same-cycle commit and issue on x6: issue wins busy/tag.
    commit(6, 1, 32'hAA); issue(6, 3); rs1 = 6;
    push_exp("x6_same", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 6;
    push_exp("x6_after", 1, 3, 32'hAA, 0, 0, 0); eval_reads(); next_cycle();

    // Rename x1..x3, then flush.
    issue(1, 1);
    push_exp("ren_x1", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    issue(2, 2); rs1 = 1;
    push_exp("ren_x2", 1, 1, 0, 0, 0, 0); eval_reads(); next_cycle();
    issue(3, 3); rs1 = 2; rs2 = 3;
    push_exp("ren_x3", 1, 2, 0, 0, 0, 32'h1234); eval_reads(); next_cycle();
    clear_all = 1'b1; issue(8, 4); commit(2, 9, 32'h55); rs1 = 3; rs2 = 2;
    push_exp("flush_cyc", 1, 3, 32'h1234, 1, 2, 0); eval_reads(); next_cycle();
    rs1 = 3; rs2 = 8;
    push_exp("flush_x3_x8", 0, 0, 32'h1234, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 2; rs2 = 6;
    push_exp("flush_x2_x6", 0, 0, 32'h55, 0, 0, 32'hAA); eval_reads(); next_cycle();
    rs1 = 1; rs2 = 4;
    push_exp("flush_x1_x4", 0, 0, 0, 0, 0, 32'd11); eval_reads(); next_cycle();

    // x0 ignores issue and commit.
    issue(0, 6); commit(0, 0, 32'hFFFF_FFFF);
    push_exp("x0_same", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    push_exp("x0_after", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();

    // Pause: no state change.
    rdy_in = 1'b0; commit(9, 0, 32'd5); issue(10, 1); rs1 = 9; rs2 = 10;
    push_exp("pause_cyc", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();
    rs1 = 9; rs2 = 10;
    push_exp("pause_after", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();

    // Reset wins over issue and commit.
    rst_in = 1'b1; issue(11, 3); commit(3, 0, 32'h77); rs1 = 3;
    push_exp("rst_cyc", 0, 0, 32'h77, 0, 0, 0);
    // x3 is not busy, so no forwarding: stored value still shows.
    sb_q[sb_q.size()-1].v1 = 32'h1234;
    eval_reads(); next_cycle();
    rs1 = 11; rs2 = 3;
    push_exp("rst_after", 0, 0, 0, 0, 0, 0); eval_reads(); next_cycle();

    // Randomized phase against the reference model (state is all-zero here).
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    for (int n = 0; n < 200; n++) begin
      commit_valid  = 1'($urandom_range(0, 1));
      commit_reg    = 5'($urandom_range(0, 7));
      commit_rob_id = ($urandom_range(0, 1) == 1) ? m_tag[commit_reg] : 4'($urandom_range(0, 15));
      commit_value  = $urandom;
      issue_valid   = 1'($urandom_range(0, 1));
      issue_rd      = 5'($urandom_range(0, 7));
      issue_rob_id  = 4'($urandom_range(0, 15));
      clear_all     = ($urandom_range(0, 15) == 0);
      rs1           = 5'($urandom_range(0, 7));
      rs2           = 5'($urandom_range(0, 7));
      model_read(rs1, b1, t1, v1);
      model_read(rs2, b2, t2, v2);
      push_exp($sformatf("rnd%0d", n), b1, t1, v1, b2, t2, v2);
      eval_reads();
      model_update();
      next_cycle();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
